// File: rtl/exhaustive_sweep_checker.sv
// Exhaustive stimulus engine: walks vec through 0..2^N-1, holds each for HOLD
// cycles, samples f_in at the end of each window and scores it against EXPECT.
module exhaustive_sweep_checker #(
  parameter int unsigned         N      = 4,
  parameter int unsigned         HOLD   = 10,
  parameter logic [(2**N)-1:0]   EXPECT = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                f_in,
  output logic [N-1:0]        vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N:0]          err_cnt,
  output logic [N-1:0]        first_fail,
  output logic [(2**N)-1:0]   captured
);

  localparam int unsigned NV = 2**N;
  localparam int unsigned HW = $clog2(HOLD) + 1;

  localparam logic [N-1:0]  VEC_LAST  = N'(NV - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     hcnt, hcnt_nxt;
  logic [N-1:0]      vec_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              pass_nxt;
  logic [N:0]        err_cnt_nxt;
  logic [N-1:0]      first_fail_nxt;
  logic [NV-1:0]     captured_nxt;
  logic              fail_seen, fail_seen_nxt;
  logic              mismatch_c;

  // State and result registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hcnt       <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      captured   <= '0;
      fail_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      vec        <= vec_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_cnt    <= err_cnt_nxt;
      first_fail <= first_fail_nxt;
      captured   <= captured_nxt;
      fail_seen  <= fail_seen_nxt;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_nxt      = state;
    hcnt_nxt       = hcnt;
    vec_nxt        = vec;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    err_cnt_nxt    = err_cnt;
    first_fail_nxt = first_fail;
    captured_nxt   = captured;
    fail_seen_nxt  = fail_seen;
    mismatch_c     = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = DRIVE;
          hcnt_nxt       = '0;
          vec_nxt        = '0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          err_cnt_nxt    = '0;
          first_fail_nxt = '0;
          captured_nxt   = '0;
          fail_seen_nxt  = 1'b0;
        end
      end

      DRIVE: begin
        if (hcnt != HCNT_LAST) begin
          hcnt_nxt = hcnt + HW'(1);
        end else begin
          // End of the hold window: score this vector.
          captured_nxt[vec] = f_in;
          mismatch_c        = (f_in != EXPECT[vec]);
          if (mismatch_c) begin
            err_cnt_nxt = err_cnt + (N+1)'(1);
            if (!fail_seen) begin
              first_fail_nxt = vec;
              fail_seen_nxt  = 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_cnt_nxt == '0);
          end else begin
            vec_nxt  = vec + N'(1);
            hcnt_nxt = '0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Bench for exhaustive_sweep_checker: randomized fault masks on a parity DUT,
// scoreboard of expected sweep results, plus reset/restart/HOLD=1 scenarios.
module tb_exhaustive_sweep_checker;

  localparam int unsigned N     = 4;
  localparam int unsigned HOLD  = 10;
  localparam int unsigned NV    = 16;
  localparam logic [15:0] GOLD  = 16'h6996;
  localparam int          SWEEP = NV * HOLD;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        f_in;
  logic [3:0]  vec;
  logic        busy, done, pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_fail;
  logic [15:0] captured;

  logic        start2;
  logic        f_in2;
  logic [1:0]  vec2;
  logic        busy2, done2, pass2;
  logic [2:0]  err_cnt2;
  logic [1:0]  first_fail2;
  logic [3:0]  captured2;

  logic [15:0] fault_mask;
  int          cyc;
  int          errors;
  int          checks;

  typedef struct {
    logic [15:0] cap;
    int          err;
    int          ff;
    logic        pass;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];

  exhaustive_sweep_checker #(.N(N), .HOLD(HOLD), .EXPECT(GOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in),
    .vec(vec), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail), .captured(captured)
  );

  exhaustive_sweep_checker #(.N(2), .HOLD(1), .EXPECT(4'b1000)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .f_in(f_in2),
    .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .first_fail(first_fail2), .captured(captured2)
  );

  // Bench-side combinational blocks under test.
  assign f_in  = (^vec) ^ fault_mask[vec];
  assign f_in2 = &vec2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what a perfect checker reports for a parity DUT with given flips.
  function automatic exp_t model(input logic [15:0] mask);
    exp_t e;
    e.cap  = '0;
    e.err  = 0;
    e.ff   = 0;
    for (int v = 0; v < NV; v++) begin
      logic [3:0] vv;
      logic       f;
      vv = 4'(v);
      f  = (^vv) ^ mask[v];
      e.cap[v] = f;
      if (f != GOLD[v]) begin
        if (e.err == 0) e.ff = v;
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input bit hold_high);
    exp_t e;
    start = 1'b1;
    tick();
    e = model(fault_mask);
    e.start_cyc = cyc;
    sb.push_back(e);
    if (!hold_high) start = 1'b0;
  endtask

  // Waits for done; drops start at once so a held start cannot retrigger.
  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    start = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_done: timeout after %0d cycles, got done=0, expected 1", bound);
    end
    tick();
  endtask

  // Monitor: on each rising done, score the reported results against the queue.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("latency",    32'(cyc - e.start_cyc), 32'(SWEEP));
          check("captured",   32'(captured),   32'(e.cap));
          check("err_cnt",    32'(err_cnt),    32'(e.err));
          check("first_fail", 32'(first_fail), 32'(e.ff));
          check("pass",       32'(pass),       32'(e.pass));
          check("vec_final",  32'(vec),        32'(15));
          check("busy_done",  32'(busy),       32'(0));
        end
      end
      done_q = done;
    end
  end

  initial begin
    logic [15:0] held_cap;
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    rst        = 1'b1;
    start      = 1'b0;
    start2     = 1'b0;
    fault_mask = '0;
    tick();
    tick();

    check("rst_vec",        32'(vec),        32'(0));
    check("rst_busy",       32'(busy),       32'(0));
    check("rst_done",       32'(done),       32'(0));
    check("rst_pass",       32'(pass),       32'(0));
    check("rst_err_cnt",    32'(err_cnt),    32'(0));
    check("rst_first_fail", 32'(first_fail), 32'(0));
    check("rst_captured",   32'(captured),   32'(0));

    // rst and start together: reset wins.
    start = 1'b1;
    tick();
    check("rst_start_busy", 32'(busy), 32'(0));
    check("rst_start_done", 32'(done), 32'(0));
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'(0));

    // Clean parity sweep.
    fault_mask = '0;
    start_sweep(1'b0);
    check("start_busy", 32'(busy), 32'(1));
    check("start_vec",  32'(vec),  32'(0));
    wait_done(SWEEP + 20);

    // Forced 1 at vec 5 and 12.
    fault_mask = 16'h1020;
    start_sweep(1'b0);
    wait_done(SWEEP + 20);
    check("two_fault_captured", 32'(captured), 32'(16'h79B6));

    // start held high for the whole sweep.
    fault_mask = $urandom_range(0, 65535);
    start_sweep(1'b1);
    repeat (40) begin
      tick();
      if (!busy) break;
    end
    check("held_start_busy", 32'(busy), 32'(1));
    wait_done(SWEEP + 20);
    held_cap = captured;
    repeat (3) tick();
    check("done_stable",     32'(done),     32'(1));
    check("captured_stable", 32'(captured), 32'(held_cap));

    // Restart from DONE clears results at the accepting edge.
    fault_mask = $urandom_range(0, 65535) & $urandom_range(0, 65535);
    start_sweep(1'b0);
    check("restart_done",     32'(done),     32'(0));
    check("restart_busy",     32'(busy),     32'(1));
    check("restart_err_cnt",  32'(err_cnt),  32'(0));
    check("restart_captured", 32'(captured), 32'(0));
    check("restart_vec",      32'(vec),      32'(0));
    wait_done(SWEEP + 20);

    // Boundaries: fault only on the last vector, all vectors faulty, then random.
    fault_mask = 16'h8000;
    start_sweep(1'b0);
    wait_done(SWEEP + 20);
    fault_mask = 16'hFFFF;
    start_sweep(1'b0);
    wait_done(SWEEP + 20);
    for (int i = 0; i < 4; i++) begin
      fault_mask = 16'($urandom) & 16'($urandom);
      start_sweep(1'b0);
      wait_done(SWEEP + 20);
    end

    // Reset mid-sweep.
    fault_mask = 16'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    check("mid_busy_pre", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_vec",      32'(vec),      32'(0));
    check("abort_busy",     32'(busy),     32'(0));
    check("abort_done",     32'(done),     32'(0));
    check("abort_captured", 32'(captured), 32'(0));
    repeat (30) tick();
    check("abort_idle_vec",  32'(vec),  32'(0));
    check("abort_idle_busy", 32'(busy), 32'(0));

    // N=2, HOLD=1: vec advances every cycle.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("h1_vec0", 32'(vec2),  32'(0));
    check("h1_busy", 32'(busy2), 32'(1));
    for (int i = 1; i < 4; i++) begin
      tick();
      check("h1_vec_step", 32'(vec2),  32'(i));
      check("h1_not_done", 32'(done2), 32'(0));
    end
    tick();
    check("h1_done",     32'(done2),     32'(1));
    check("h1_pass",     32'(pass2),     32'(1));
    check("h1_captured", 32'(captured2), 32'(4'b1000));
    check("h1_err_cnt",  32'(err_cnt2),  32'(0));
    check("h1_vec_hold", 32'(vec2),      32'(3));

    tick();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweep_checker.md
Name: exhaustive_sweep_checker

Overview:
Parametrised, self-checking exhaustive stimulus engine for N-input single-output combinational blocks. On start it drives every input vector 0..2^N-1 in ascending order and holds each for HOLD cycles. At the end of each hold window it samples the DUT output and compares it against a golden truth table. It reports a pass/fail verdict, a mismatch count, the first failing vector and the full captured truth table. The DUT sits between vec and f_in.

Parameters:
N, 4, number of DUT inputs (1..8)
HOLD, 10, clock cycles each vector is held (>=1)
EXPECT, {2**N{1'b0}}, golden truth table; bit i = expected f for vec==i

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE or DONE
f_in  input  1  DUT output under test
vec  output  N  current stimulus vector to DUT inputs
busy  output  1  high while sweep in progress
done  output  1  high from sweep completion until next accepted start or rst
pass  output  1  valid when done; 1 iff zero mismatches
err_cnt  output  N+1  number of mismatching vectors (max 2^N)
first_fail  output  N  lowest vector that mismatched; 0 if none
captured  output  2**N  sampled f_in; bit i = value observed for vec==i

Behaviour:
- All outputs are registered. Internal hold counter hcnt has width clog2(HOLD)+1.
- Reset (rst=1 at a rising edge, in any state including mid-sweep): state=IDLE, vec=0, hcnt=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, captured=0, fail_seen=0. rst has priority over start.
- States: IDLE, DRIVE, DONE.
- IDLE: start=1 at edge k -> DRIVE. At that edge: vec=0, hcnt=0, busy=1, done=0, pass=0, err_cnt=0, first_fail=0, captured=0, fail_seen=0.
- DRIVE, hcnt != HOLD-1: hcnt++. vec is unchanged.
- DRIVE, hcnt == HOLD-1 (sample edge):
  - captured[vec] <= f_in.
  - If f_in != EXPECT[vec]: err_cnt++. If fail_seen=0, also set first_fail <= vec and fail_seen <= 1.
  - If vec == 2^N-1: enter DONE with busy=0 and done=1. pass = (updated err_cnt == 0), including this final sample. vec holds at 2^N-1.
  - Otherwise: vec++ and hcnt=0.
- Timing: each vector is driven for exactly HOLD cycles. f_in is sampled on the final edge of its window. done rises at edge k + 2^N*HOLD.
- HOLD=1: a sample occurs every cycle and vec advances every cycle.
- start is ignored while busy, whether held high or pulsed.
- DONE: all results are held stable. start=1 restarts exactly as from IDLE, clearing all results at the same edge.
- err_cnt cannot overflow because its width is N+1.
- vec never wraps within a sweep.
- f_in is treated as already synchronous; no metastability handling.

Test Plan:
1. N=4, HOLD=10, EXPECT=16'h6996, bench f_in = ^vec; pulse start -> done at 160 cycles after the start edge, pass=1, err_cnt=0, first_fail=0, captured=16'h6996.
2. Same setup but f_in forced to 1 when vec==5 and when vec==12 -> err_cnt=2, first_fail=5, pass=0, captured=16'h79B6.
3. start held high throughout the sweep -> exactly one sweep, done at +160 cycles. After done, deassert start, then pulse it -> next edge done=0, busy=1, err_cnt=0, captured=0, vec=0.
4. rst asserted for one cycle at cycle 50 of a sweep -> next edge: vec=0, busy=0, done=0, captured=0, state IDLE. No further vec changes without start.
5. N=2, HOLD=1, EXPECT=4'b1000, f_in = &vec -> vec sequence 0,1,2,3 on consecutive cycles, done at +4 cycles, pass=1, captured=4'b1000.
6. rst and start both high on the same edge -> reset values; busy stays 0.
